// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : Instruction decode stage of the GPU pipeline. Splits the fetched
//            instruction into fields and reads a 16x32 register file that has
//            write-to-read bypass. Registers the decoded operands into the EX
//            slot. Owns the zero-overhead hardware loop (LSET/LEND): redirects
//            fetch through Loop/PC_in and squashes the wrong-path slots that
//            fetch has already issued.
// Ports    : CLOCK_50, reset (async, active-high)
//            id_instr, id_pc            - from fetch (id_pc leads id_instr by 1)
//            wb_we, wb_rd, wb_data      - register writeback port
//            Loop, PC_in                - redirect request back to fetch
//            ex_valid, ex_op, ex_rd,
//            ex_a, ex_b, ex_imm, ex_pc  - decoded EX slot
//            loop_active                - loop counter is non-zero
// Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int SQUASH = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [31:0]       id_instr,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              wb_we,
  input  logic [3:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              Loop,
  output logic [PC_W-1:0]   PC_in,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [3:0]        ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PC_W-1:0]   ex_pc,
  output logic              loop_active
);

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_LSET = 4'hE;
  localparam logic [3:0] c_OP_LEND = 4'hF;
  localparam int         c_SQ_W    = $clog2(SQUASH + 1);

  // Instruction fields
  logic [3:0]  w_op, w_rd, w_rs, w_rt;
  logic [15:0] w_imm;

  assign w_op  = id_instr[31:28];
  assign w_rd  = id_instr[27:24];
  assign w_rs  = id_instr[23:20];
  assign w_rt  = id_instr[19:16];
  assign w_imm = id_instr[15:0];

  // State
  logic [DATA_W-1:0] rf_q [16];
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       cnt_q,    cnt_d;
  logic [PC_W-1:0]   start_q,  start_d;
  logic [c_SQ_W-1:0] squash_q, squash_d;
  logic              loop_q,   loop_d;

  logic              w_squashing;
  logic              w_valid;
  logic [DATA_W-1:0] w_a, w_b, w_imm_ext;

  // The current id_instr is wrong-path whenever squash slots remain; this
  // includes the cycle in which Loop is being presented to fetch.
  assign w_squashing = (squash_q != '0);

  assign w_valid = (w_op != c_OP_NOP) && (w_op != c_OP_LSET) &&
                   (w_op != c_OP_LEND) && !w_squashing;

  assign w_imm_ext = {{(DATA_W-16){w_imm[15]}}, w_imm};

  // Register read with bypass from the same-cycle writeback.
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (w_rs != 4'd0) begin
      w_a = (wb_we && (wb_rd == w_rs)) ? wb_data : rf_q[w_rs];
    end
    if (w_rt != 4'd0) begin
      w_b = (wb_we && (wb_rd == w_rt)) ? wb_data : rf_q[w_rt];
    end
  end

  // Register file; entry 0 is never written so it always reads zero.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_we && (wb_rd != 4'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Loop control next-state. LSET/LEND arriving in a squashed slot belong to
  // the wrong path and must not touch the loop state.
  always_comb begin
    cnt_d    = cnt_q;
    start_d  = start_q;
    loop_d   = 1'b0;
    squash_d = w_squashing ? (squash_q - 1'b1) : '0;
    if (!w_squashing) begin
      if (w_op == c_OP_LSET) begin
        cnt_d   = w_imm;
        start_d = pc_q + 1'b1;
      end else if (w_op == c_OP_LEND) begin
        if (cnt_q > 16'd1) begin
          cnt_d  = cnt_q - 16'd1;
          loop_d = 1'b1;
        end else begin
          cnt_d  = 16'd0;
        end
      end
    end
    if (loop_d) begin
      squash_d = c_SQ_W'(SQUASH);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      cnt_q    <= '0;
      start_q  <= '0;
      squash_q <= '0;
      loop_q   <= 1'b0;
    end else begin
      pc_q     <= id_pc;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      squash_q <= squash_d;
      loop_q   <= loop_d;
    end
  end

  // EX slot: fields load every cycle, only ex_valid reflects squash/op type.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_pc    <= '0;
    end else begin
      ex_valid <= w_valid;
      ex_op    <= w_op;
      ex_rd    <= w_rd;
      ex_a     <= w_a;
      ex_b     <= w_b;
      ex_imm   <= w_imm_ext;
      ex_pc    <= pc_q;
    end
  end

  assign Loop        = loop_q;
  assign PC_in       = start_q;
  assign loop_active = (cnt_q != 16'd0);

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Self-checking bench for id_stage: directed scenarios plus a
//            random phase, all compared against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [31:0] id_instr;
  logic [15:0] id_pc;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        Loop;
  logic [15:0] PC_in;
  logic        ex_valid;
  logic [3:0]  ex_op, ex_rd;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [15:0] ex_pc;
  logic        loop_active;

  id_stage dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .Loop        (Loop),
    .PC_in       (PC_in),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_rd       (ex_rd),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_imm      (ex_imm),
    .ex_pc       (ex_pc),
    .loop_active (loop_active)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_rf [16];
  int          m_cnt;
  logic [15:0] m_start;
  int          m_sq;
  logic [15:0] m_pcd;
  logic        m_loop;

  // Program memory for the fetch emulation
  logic [31:0] mem [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_cnt   = 0;
    m_start = '0;
    m_sq    = 0;
    m_pcd   = '0;
    m_loop  = 1'b0;
  endtask

  function automatic logic [31:0] rd_reg(input logic [3:0] r);
    if (r == 4'd0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  // One clock: predict from current inputs, advance, compare every output.
  task automatic cycle();
    logic [3:0]  op;
    logic [15:0] imm;
    logic        sq_now, e_valid, nl;
    logic [31:0] e_a, e_b, e_imm;
    logic [15:0] e_pc;
    op      = id_instr[31:28];
    imm     = id_instr[15:0];
    sq_now  = (m_sq > 0);
    e_valid = !(op == 4'h0 || op == 4'hE || op == 4'hF) && !sq_now;
    e_a     = rd_reg(id_instr[23:20]);
    e_b     = rd_reg(id_instr[19:16]);
    e_imm   = {{16{imm[15]}}, imm};
    e_pc    = m_pcd;
    nl      = 1'b0;
    if (!sq_now) begin
      if (op == 4'hE) begin
        m_cnt   = int'(imm);
        m_start = m_pcd + 16'd1;
      end else if (op == 4'hF) begin
        if (m_cnt > 1) begin
          m_cnt = m_cnt - 1;
          nl    = 1'b1;
        end else begin
          m_cnt = 0;
        end
      end
    end
    m_sq   = nl ? 2 : (m_sq > 0 ? m_sq - 1 : 0);
    m_loop = nl;
    if (wb_we && wb_rd != 4'd0) m_rf[wb_rd] = wb_data;
    m_pcd = id_pc;
    @(posedge CLOCK_50);
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, e_valid});
    chk("ex_op", {28'd0, ex_op}, {28'd0, op});
    chk("ex_rd", {28'd0, ex_rd}, {28'd0, id_instr[27:24]});
    chk("ex_a", ex_a, e_a);
    chk("ex_b", ex_b, e_b);
    chk("ex_imm", ex_imm, e_imm);
    chk("ex_pc", {16'd0, ex_pc}, {16'd0, e_pc});
    chk("Loop", {31'd0, Loop}, {31'd0, m_loop});
    chk("PC_in", {16'd0, PC_in}, {16'd0, m_start});
    chk("loop_active", {31'd0, loop_active}, {31'd0, (m_cnt != 0)});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_Loop"}, {31'd0, Loop}, 32'd0);
    chk({tag, "_PC_in"}, {16'd0, PC_in}, 32'd0);
    chk({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_ex_op"}, {28'd0, ex_op}, 32'd0);
    chk({tag, "_ex_rd"}, {28'd0, ex_rd}, 32'd0);
    chk({tag, "_ex_a"}, ex_a, 32'd0);
    chk({tag, "_ex_b"}, ex_b, 32'd0);
    chk({tag, "_ex_imm"}, ex_imm, 32'd0);
    chk({tag, "_ex_pc"}, {16'd0, ex_pc}, 32'd0);
    chk({tag, "_loop_active"}, {31'd0, loop_active}, 32'd0);
  endtask

  // Assert reset between edges, check outputs cleared without a clock,
  // hold it across one edge, release.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic rand_cycle();
    id_instr = $urandom;
    id_pc    = 16'($urandom);
    wb_we    = 1'($urandom);
    wb_rd    = 4'($urandom);
    wb_data  = $urandom;
    cycle();
  endtask

  initial begin
    int          loops_seen, body_issues, tail_issues, guard;
    logic [15:0] fp, st;
    logic [31:0] cur;
    logic        lnow, hit;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h10] = 32'hE000_0003;   // LSET imm=3
    mem[8'h11] = 32'h1110_0000;
    mem[8'h12] = 32'h2120_0001;
    mem[8'h13] = 32'h3130_0002;
    mem[8'h14] = 32'hF000_0000;   // LEND
    mem[8'h15] = 32'h2200_0000;
    mem[8'h16] = 32'h2300_0000;

    reset    = 1'b1;
    id_instr = '0;
    id_pc    = '0;
    wb_we    = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_all_zero("por");
    reset = 1'b0;

    // 1: mid-run reset
    repeat (20) rand_cycle();
    do_reset("rst_mid");
    id_instr = 32'd0; id_pc = 16'd0; wb_we = 1'b0;
    cycle();
    chk("post_rst_nop_valid", {31'd0, ex_valid}, 32'd0);

    // 2: writeback then read
    wb_we = 1'b1; wb_rd = 4'd3; wb_data = 32'h1234_5678; id_instr = 32'd0;
    cycle();
    wb_we = 1'b0; id_instr = 32'h1230_0000;
    cycle();
    chk("t2_valid", {31'd0, ex_valid}, 32'd1);
    chk("t2_op", {28'd0, ex_op}, 32'd1);
    chk("t2_rd", {28'd0, ex_rd}, 32'd2);
    chk("t2_a", ex_a, 32'h1234_5678);
    chk("t2_b", ex_b, 32'd0);

    // 3: bypass, and R0 stays zero
    wb_we = 1'b1; wb_rd = 4'd5; wb_data = 32'h0000_00A5; id_instr = 32'h1050_0000;
    cycle();
    chk("t3_bypass", ex_a, 32'h0000_00A5);
    wb_rd = 4'd0; wb_data = 32'h0000_00FF; id_instr = 32'h1000_0000;
    cycle();
    chk("t3_r0_bypass", ex_a, 32'd0);
    wb_we = 1'b0;
    cycle();
    chk("t3_r0_read", ex_a, 32'd0);

    // 4: immediate sign extension
    id_instr = 32'h1000_8000;
    cycle();
    chk("t4_imm_neg", ex_imm, 32'hFFFF_8000);
    id_instr = 32'h1000_7FFF;
    cycle();
    chk("t4_imm_pos", ex_imm, 32'h0000_7FFF);

    // 5: hardware loop with emulated fetch
    loops_seen = 0; body_issues = 0; tail_issues = 0;
    fp = 16'h0010; cur = 32'd0;
    for (int n = 0; n < 30; n++) begin
      id_pc = fp; id_instr = cur;
      lnow = m_loop; st = m_start;
      cycle();
      if (Loop === 1'b1) begin
        loops_seen++;
        chk("t5_pc_in", {16'd0, PC_in}, 32'h0000_0011);
      end
      if (ex_valid === 1'b1 && ex_pc === 16'h0011) body_issues++;
      if (ex_valid === 1'b1 && ex_pc === 16'h0015) tail_issues++;
      cur = mem[fp[7:0]];
      fp  = lnow ? st : fp + 16'd1;
    end
    chk("t5_loop_pulses", loops_seen, 32'd2);
    chk("t5_body_issues", body_issues, 32'd3);
    chk("t5_tail_issues", tail_issues, 32'd1);
    chk("t5_loop_active_end", {31'd0, loop_active}, 32'd0);

    // 6: reset during the first squash cycle
    do_reset("rst_pre6");
    fp = 16'h0010; cur = 32'd0; hit = 1'b0; guard = 0;
    while (!hit && guard < 40) begin
      id_pc = fp; id_instr = cur;
      lnow = m_loop; st = m_start;
      cycle();
      cur = mem[fp[7:0]];
      fp  = lnow ? st : fp + 16'd1;
      hit = m_loop;
      guard++;
    end
    chk("t6_loop_reached", {31'd0, hit}, 32'd1);
    do_reset("rst_squash");
    id_instr = 32'h1230_0000; id_pc = 16'h0040; wb_we = 1'b0;
    cycle();
    chk("t6_valid_after", {31'd0, ex_valid}, 32'd1);
    chk("t6_loop_after", {31'd0, Loop}, 32'd0);

    // Random phase: ops, writebacks and loops all mixed
    repeat (400) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
